// File: rtl/vip_axi_burst_writer.sv
// rtl/vip_axi_burst_writer.sv - coalesces a word stream into buffered AXI4 INCR write bursts
// Default AXI channel types sized for 48-bit address, 64-bit data, 2-bit ID.
package vip_axi_burst_writer_pkg;
  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module vip_axi_burst_writer #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned IdWidth       = 2,
  parameter int unsigned AxiId         = 0,
  parameter int unsigned MaxBeats      = 16,
  parameter int unsigned TimeoutCycles = 32,
  parameter type axi_req_t = vip_axi_burst_writer_pkg::axi_req_t,
  parameter type axi_rsp_t = vip_axi_burst_writer_pkg::axi_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   wr_addr_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic [DataWidth/8-1:0] wr_strb_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic                   flush_i,
  output axi_req_t               axi_req_o,
  input  axi_rsp_t               axi_rsp_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [31:0]            bursts_o
);
  localparam int unsigned Bytes = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(Bytes);
  localparam int unsigned CntW  = $clog2(MaxBeats + 1);
  localparam int unsigned IdxW  = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
  localparam int unsigned TmoW  = $clog2(TimeoutCycles + 2);

  typedef enum logic [2:0] {IDLE, FILL, AW, W, B} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] base_q, addr_al, next_addr;
  logic [CntW-1:0]      beats_q, beats_d, rd_q, rd_d;
  logic [TmoW-1:0]      tmo_q;
  logic                 live_q, err_q;
  logic [31:0]          bursts_q;
  logic [DataWidth-1:0] mem_data [MaxBeats];
  logic [Bytes-1:0]     mem_strb [MaxBeats];
  logic [IdxW-1:0]      wr_idx;
  logic                 fill_ok, fire, timeout, last_beat;

  assign addr_al   = {wr_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
  assign next_addr = base_q + (AddrWidth'(beats_q) << OffW);
  // Contiguous, room left, and still inside the 4 KiB page of the burst base.
  assign fill_ok   = (beats_q < CntW'(MaxBeats)) && (addr_al == next_addr) &&
                     (addr_al[AddrWidth-1:12] == base_q[AddrWidth-1:12]);
  assign wr_ready_o = live_q && ((state_q == IDLE) || ((state_q == FILL) && fill_ok));
  assign fire      = wr_valid_i && wr_ready_o;
  assign timeout   = (TimeoutCycles != 0) && !wr_valid_i &&
                     (tmo_q == TmoW'(int'(TimeoutCycles) - 1));
  assign last_beat = (rd_q == beats_q - CntW'(1));
  assign wr_idx    = (state_q == IDLE) ? '0 : IdxW'(beats_q);

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (fire) begin
        beats_d = CntW'(1);
        state_d = FILL;
      end
      FILL: begin
        beats_d = beats_q + CntW'(fire);
        if ((beats_d == CntW'(MaxBeats)) || (wr_valid_i && !fill_ok) || flush_i || timeout)
          state_d = AW;
      end
      AW: begin
        rd_d = '0;
        if (axi_rsp_i.aw_ready) state_d = W;
      end
      W: if (axi_rsp_i.w_ready) begin
        if (last_beat) state_d = B;
        else           rd_d = rd_q + CntW'(1);
      end
      B: if (axi_rsp_i.b_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      base_q   <= '0;
      beats_q  <= '0;
      rd_q     <= '0;
      tmo_q    <= '0;
      live_q   <= 1'b0;
      err_q    <= 1'b0;
      bursts_q <= '0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      beats_q <= beats_d;
      rd_q    <= rd_d;
      tmo_q   <= ((state_q == FILL) && !wr_valid_i) ? tmo_q + TmoW'(1) : '0;
      if ((state_q == IDLE) && fire) base_q <= addr_al;
      if ((state_q == B) && axi_rsp_i.b_valid) begin
        bursts_q <= bursts_q + 32'd1;
        if (axi_rsp_i.b.resp != 2'b00) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire) begin
      mem_data[wr_idx] <= wr_data_i;
      mem_strb[wr_idx] <= wr_strb_i;
    end
  end

  always_comb begin
    axi_req_o         = '0;
    axi_req_o.r_ready = live_q;
    if (state_q == AW) begin
      axi_req_o.aw_valid = 1'b1;
      axi_req_o.aw.id    = IdWidth'(AxiId);
      axi_req_o.aw.addr  = base_q;
      axi_req_o.aw.len   = 8'(beats_q) - 8'd1;
      axi_req_o.aw.size  = 3'(OffW);
      axi_req_o.aw.burst = 2'b01;
    end
    if (state_q == W) begin
      axi_req_o.w_valid = 1'b1;
      axi_req_o.w.data  = mem_data[IdxW'(rd_q)];
      axi_req_o.w.strb  = mem_strb[IdxW'(rd_q)];
      axi_req_o.w.last  = last_beat;
    end
    if (state_q == B) axi_req_o.b_ready = 1'b1;
  end

  assign busy_o   = (state_q != IDLE);
  assign err_o    = err_q;
  assign bursts_o = bursts_q;

  logic unused_ok;
  assign unused_ok = ^{axi_rsp_i.ar_ready, axi_rsp_i.r_valid, axi_rsp_i.r,
                       axi_rsp_i.b.id, axi_rsp_i.b.user, wr_addr_i[OffW-1:0]};
endmodule

// File: tb/tb_vip_axi_burst_writer.sv
// tb/tb_vip_axi_burst_writer.sv - scoreboard bench with a reactive AXI slave model
module tb_vip_axi_burst_writer;
  import vip_axi_burst_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_strb = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        flush = 1'b0;
  logic        busy, err;
  logic [31:0] bursts;
  axi_req_t    req;
  axi_rsp_t    rsp;

  always #5 clk = ~clk;

  vip_axi_burst_writer #(.MaxBeats(16), .TimeoutCycles(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_strb_i(wr_strb), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .flush_i(flush), .axi_req_o(req), .axi_rsp_i(rsp), .busy_o(busy),
    .err_o(err), .bursts_o(bursts)
  );

  typedef struct {logic [47:0] addr; logic [7:0] len;} burst_t;
  typedef struct {logic [63:0] data; logic [7:0] strb;} beat_t;
  burst_t exp_aw[$];
  beat_t  exp_w[$];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int aw_delay = 0, w_mode = 0, aw_cnt = 0;
  logic [1:0] bresp = 2'b00;
  int cur_len = 0, beat_idx = 0, n_last = 0;
  int aw_cyc = 0, acc_cyc = 0;
  bit aw_prev = 0, aw_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave + monitor: observe handshakes at negedge, react 1 time unit after posedge.
  initial begin
    rsp = '0;
    forever begin
      bit awf, wf, bf, wl;
      burst_t e;
      beat_t  b;
      @(negedge clk);
      awf = req.aw_valid && rsp.aw_ready;
      wf  = req.w_valid && rsp.w_ready;
      bf  = req.b_ready && rsp.b_valid;
      wl  = req.w.last;
      if (req.aw_valid && !aw_prev) aw_cyc = cyc;
      aw_prev = req.aw_valid;
      if (req.w_valid) check_eq("w_after_aw", aw_acc, 1);
      if (awf) begin
        check_eq("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          e = exp_aw.pop_front();
          check_eq("aw_addr", req.aw.addr, e.addr);
          check_eq("aw_len", req.aw.len, e.len);
          check_eq("aw_size", req.aw.size, 3);
          check_eq("aw_burst", req.aw.burst, 1);
          cur_len  = e.len;
          beat_idx = 0;
        end
      end
      if (wf) begin
        check_eq("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          b = exp_w.pop_front();
          check_eq("w_data", req.w.data, b.data);
          check_eq("w_strb", req.w.strb, b.strb);
          check_eq("w_last", wl, beat_idx == cur_len);
        end
        beat_idx++;
        if (wl) n_last++;
      end
      @(posedge clk);
      #1;
      if (awf) aw_acc = 1;
      if (bf) aw_acc = 0;
      if (awf || !req.aw_valid) begin
        rsp.aw_ready = 1'b0;
        aw_cnt = 0;
      end else if (aw_cnt >= aw_delay) rsp.aw_ready = 1'b1;
      else aw_cnt++;
      case (w_mode)
        0: rsp.w_ready = 1'b1;
        1: rsp.w_ready = ~rsp.w_ready;
        default: rsp.w_ready = 1'b0;
      endcase
      if (bf) rsp.b_valid = 1'b0;
      if (wf && wl) begin
        rsp.b_valid = 1'b1;
        rsp.b.resp  = bresp;
      end
      if (!rst_n) begin
        rsp = '0;
        aw_acc = 0;
        aw_cnt = 0;
        aw_prev = 0;
      end
    end
  end

  task automatic send_word(input logic [47:0] a, input logic [63:0] d, input logic [7:0] s);
    int t = 0;
    beat_t bt;
    bt.data = d;
    bt.strb = s;
    exp_w.push_back(bt);
    wr_addr = a; wr_data = d; wr_strb = s; wr_valid = 1'b1;
    do begin @(negedge clk); t++; end while (!wr_ready && t < 300);
    check_eq("word_accepted", wr_ready, 1);
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic push_burst(input logic [47:0] a, input logic [7:0] l);
    burst_t e;
    e.addr = a;
    e.len  = l;
    exp_aw.push_back(e);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end
    while ((busy || exp_aw.size() != 0 || exp_w.size() != 0) && t < 2000);
    check_eq("drained", t < 2000, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int snap, t;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_bursts", bursts, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_req_zero", req == '0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_wr_ready", wr_ready, 1);

    push_burst(48'h8000_0000, 0);
    send_word(48'h8000_0000, 64'hDEAD_BEEF, 8'hFF);
    do_flush();
    wait_idle();
    check_eq("bursts_single", bursts, 1);

    push_burst(48'h1000, 15);
    push_burst(48'h1080, 3);
    for (int i = 0; i < 20; i++)
      send_word(48'h1000 + 48'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i), 8'(8'hF0 ^ i));
    do_flush();
    wait_idle();
    check_eq("bursts_split16", bursts, 3);

    push_burst(48'h0FF0, 1);
    push_burst(48'h1000, 0);
    send_word(48'h0FF0, 64'h1111, 8'h0F);
    send_word(48'h0FF8, 64'h2222, 8'hFF);
    send_word(48'h1000, 64'h3333, 8'h3C);
    do_flush();
    wait_idle();
    check_eq("bursts_4k", bursts, 5);

    push_burst(48'h100, 1);
    push_burst(48'h200, 0);
    send_word(48'h100, 64'h0100, 8'hFF);
    send_word(48'h108, 64'h0108, 8'hFF);
    send_word(48'h200, 64'h0200, 8'h81);
    do_flush();
    wait_idle();
    check_eq("bursts_gap", bursts, 7);

    aw_delay = 5; w_mode = 1; bresp = 2'b10;
    snap = n_last;
    push_burst(48'h2000, 3);
    for (int i = 0; i < 4; i++)
      send_word(48'h2000 + 48'(i * 8), $urandom, 8'hFF);
    do_flush();
    wait_idle();
    check_eq("one_w_last", n_last - snap, 1);
    check_eq("err_slverr", err, 1);
    bresp = 2'b00;
    push_burst(48'h3000, 0);
    send_word(48'h3000, 64'h3000, 8'hFF);
    do_flush();
    wait_idle();
    check_eq("err_sticky", err, 1);
    check_eq("bursts_slv", bursts, 9);
    aw_delay = 0; w_mode = 0;

    push_burst(48'h4000, 2);
    for (int i = 0; i < 3; i++) send_word(48'h4000 + 48'(i * 8), 64'(i + 40), 8'hFF);
    wait_idle();
    check_eq("timeout_latency", aw_cyc - acc_cyc, 32);
    check_eq("bursts_timeout", bursts, 10);

    w_mode = 2;
    push_burst(48'h5000, 3);
    for (int i = 0; i < 4; i++) send_word(48'h5000 + 48'(i * 8), 64'(i), 8'hFF);
    do_flush();
    t = 0;
    do begin @(negedge clk); t++; end while (!req.w_valid && t < 200);
    check_eq("reached_w", req.w_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_err", err, 0);
    check_eq("mid_rst_bursts", bursts, 0);
    check_eq("mid_rst_wr_ready", wr_ready, 0);
    check_eq("mid_rst_req_zero", req == '0, 1);
    exp_aw.delete();
    exp_w.delete();
    w_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_burst(48'h6000, 0);
    send_word(48'h6000, 64'h6666, 8'hFF);
    do_flush();
    wait_idle();
    check_eq("post_rst_bursts", bursts, 1);
    check_eq("post_rst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
